cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_pkg.sv | 28 ++
 rtl/cdb_rr_picker.sv | 35 +++
 rtl/cdb_arbiter.sv | 125 ++++++++++++
 tb/tb_cdb_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdb_pkg: shared types and constants for the CDB arbiter slice.       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package cdb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } cdb_state_t;

  localparam int ADDER_UNIT = 0;
  localparam int MULT_UNIT  = 1;
  localparam int LOAD_UNIT  = 2;
  localparam int STORE_UNIT = 3;

  localparam logic [5:0] CDB_NO_SOURCE = 6'b000000;
  localparam int DEFAULT_HOLD_CYCLES = 2;

  // Index width that stays at least one bit for a single-unit bus.
  function automatic int cdb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdb_rr_picker: combinational search for the first requester after ptr.|
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module cdb_rr_picker
  import cdb_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int IDX_W     = cdb_idx_w(NUM_UNITS)
) (
  input  logic [NUM_UNITS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     winner
);

  logic [IDX_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    w_idx  = '0;
    for (int k = NUM_UNITS; k >= 1; k--) begin
      w_idx = IDX_W'((int'(ptr) + k) % NUM_UNITS);
      if (req[w_idx]) begin
        found  = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdb_arbiter: common-data-bus grant FSM (IDLE/GRANT/RELEASE).         |
// | Macro CDB_ARB_ROUND_ROBIN_EN selects round-robin; else fixed priority.|
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int  NUM_UNITS   = 4,
  parameter int  HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  localparam int IDX_W       = cdb_idx_w(NUM_UNITS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_UNITS-1:0] CDB_rts,
  output logic [NUM_UNITS-1:0] CDB_xmit,
  input  logic                 CDB_write,
  output logic                 bus_busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 protocol_error
);

  localparam logic [3:0]           c_hold = 4'(HOLD_CYCLES);
  localparam logic [NUM_UNITS-1:0] c_one  = NUM_UNITS'(1);
  localparam logic [IDX_W-1:0]     c_last = IDX_W'(NUM_UNITS - 1);

  cdb_state_t            r_state, w_state_nxt;
  logic [NUM_UNITS-1:0]  r_xmit, w_xmit_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]      r_gid, w_gid_nxt;
  logic                  r_perr, w_perr_nxt;
  logic [IDX_W-1:0]      w_ptr;
  logic                  w_found;
  logic [IDX_W-1:0]      w_winner;

`ifdef CDB_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_ptr <= c_last;
    else if (r_state == ST_RELEASE)
      r_ptr <= r_gid;
  end

  assign w_ptr = r_ptr;
`else
  // A pointer parked on the last unit turns the search into lowest-index-first.
  assign w_ptr = c_last;
`endif

  cdb_rr_picker #(
    .NUM_UNITS (NUM_UNITS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req    (CDB_rts),
    .ptr    (w_ptr),
    .found  (w_found),
    .winner (w_winner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_xmit  <= '0;
      r_cnt   <= '0;
      r_gid   <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_xmit  <= w_xmit_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gid   <= w_gid_nxt;
      r_perr  <= w_perr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_xmit_nxt  = r_xmit;
    w_cnt_nxt   = r_cnt;
    w_gid_nxt   = r_gid;
    unique case (r_state)
      ST_IDLE: begin
        w_xmit_nxt = '0;
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_xmit_nxt  = c_one << w_winner;
          w_gid_nxt   = w_winner;
          w_cnt_nxt   = c_hold;
        end
      end
      ST_GRANT: begin
        // Last hold cycle or the grantee withdrew its request: drop the bus.
        if (r_cnt <= 4'd1 || !CDB_rts[r_gid]) begin
          w_state_nxt = ST_RELEASE;
          w_xmit_nxt  = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_xmit_nxt  = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_xmit_nxt  = '0;
        w_cnt_nxt   = '0;
      end
    endcase

    w_perr_nxt = (CDB_write && (r_xmit == '0)) ||
                 ((r_state == ST_RELEASE) && CDB_rts[r_gid]);
  end

  assign CDB_xmit       = r_xmit;
  assign bus_busy       = (r_state != ST_IDLE);
  assign grant_id       = r_gid;
  assign protocol_error = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cdb_arbiter: directed self-checking bench for cdb_arbiter.        |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_cdb_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rts, rts4;
  logic       wr, wr4;
  logic [3:0] xmit, xmit4;
  logic       busy, busy4;
  logic [1:0] gid, gid4;
  logic       perr, perr4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_UNITS(4), .HOLD_CYCLES(2)) u_dut (
    .clock          (clk),
    .reset          (rst),
    .CDB_rts        (rts),
    .CDB_xmit       (xmit),
    .CDB_write      (wr),
    .bus_busy       (busy),
    .grant_id       (gid),
    .protocol_error (perr)
  );

  cdb_arbiter #(.NUM_UNITS(4), .HOLD_CYCLES(4)) u_dut4 (
    .clock          (clk),
    .reset          (rst),
    .CDB_rts        (rts4),
    .CDB_xmit       (xmit4),
    .CDB_write      (wr4),
    .bus_busy       (busy4),
    .grant_id       (gid4),
    .protocol_error (perr4)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  int         exp_seq [5];
  logic [3:0] mask;

  initial begin
`ifdef CDB_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 2, 3, 0};
`else
    exp_seq = '{0, 0, 0, 0, 0};
`endif
    rst = 1'b1; rts = '0; rts4 = '0; wr = 1'b0; wr4 = 1'b0;
    #2;
    chk("rst_xmit", 32'(xmit), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gid", 32'(gid), 32'h0);
    chk("rst_perr", 32'(perr), 32'h0);
    chk("rst_xmit4", 32'(xmit4), 32'h0);
    step(2);
    rst = 1'b0;

    // Single requester, full hold, turnaround, then idle.
    rts = 4'b0001;
    step(1);
    chk("single_xmit_c1", 32'(xmit), 32'h1);
    chk("single_gid", 32'(gid), 32'h0);
    chk("single_busy", 32'(busy), 32'h1);
    step(1);
    chk("single_xmit_c2", 32'(xmit), 32'h1);
    step(1);
    chk("single_release_xmit", 32'(xmit), 32'h0);
    chk("single_release_busy", 32'(busy), 32'h1);
    step(1);
    chk("single_idle_busy", 32'(busy), 32'h0);
    chk("single_idle_xmit", 32'(xmit), 32'h0);
    chk("rts_in_release_perr", 32'(perr), 32'h1);
    rts = '0;
    step(1);
    chk("perr_pulse_end", 32'(perr), 32'h0);
    chk("idle_stays_idle", 32'(busy), 32'h0);

    // Early abort on the 4-cycle hold instance.
    rts4 = 4'b0100;
    step(1);
    chk("abort_grant_xmit", 32'(xmit4), 32'h4);
    chk("abort_grant_gid", 32'(gid4), 32'h2);
    rts4 = '0;
    step(1);
    chk("abort_xmit_off", 32'(xmit4), 32'h0);
    chk("abort_release_busy", 32'(busy4), 32'h1);
    step(1);
    chk("abort_idle_busy", 32'(busy4), 32'h0);
    chk("abort_no_perr", 32'(perr4), 32'h0);

    // Write strobe with no grantee.
    wr = 1'b1;
    step(1);
    chk("idle_write_perr", 32'(perr), 32'h1);
    chk("idle_write_busy", 32'(busy), 32'h0);
    wr = 1'b0;
    step(1);
    chk("idle_write_perr_end", 32'(perr), 32'h0);

    // Write strobe by a legitimate grantee is not an error.
    rts = 4'b0010;
    step(1);
    chk("write_grant_gid", 32'(gid), 32'h1);
    wr = 1'b1;
    step(1);
    chk("granted_write_perr", 32'(perr), 32'h0);
    wr = 1'b0;
    rts = '0;
    step(3);

    // All units requesting: grant order and 4-cycle spacing.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    rts = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step(1);
      mask = 4'b0001 << exp_seq[i];
      chk($sformatf("all_gid_%0d", i), 32'(gid), 32'(exp_seq[i]));
      chk($sformatf("all_xmit_%0d", i), 32'(xmit), 32'(mask));
      if (i < 4) begin
        step(2);
        chk($sformatf("all_release_%0d", i), 32'({busy, xmit}), 32'h10);
        step(1);
        chk($sformatf("all_idle_%0d", i), 32'({busy, xmit}), 32'h00);
      end
    end
    rts = '0;
    step(3);

    // Reset in the middle of a grant.
    rts = 4'b0100;
    step(1);
    chk("mid_grant_gid", 32'(gid), 32'h2);
    chk("mid_grant_xmit", 32'(xmit), 32'h4);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_xmit", 32'(xmit), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_gid", 32'(gid), 32'h0);
    rts = 4'b1010;
    step(1);
    rst = 1'b0;
    step(1);
    chk("post_rst_gid", 32'(gid), 32'h1);
    chk("post_rst_xmit", 32'(xmit), 32'h2);
    rts = '0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
